// File: rtl/spi_deserializer.sv
// ============================================================================
//  Module      : spi_deserializer
//  Description : SPI slave receive path. The serial inputs are synchronized
//                into the clk domain, edges are detected, and a WORD_BITS
//                frame shifted MSB first is delivered on Data_Out with a
//                one-cycle data_valid strobe.
//                Optional feature macro: SPI_DESER_FRAME_CHECK_EN
//                  defined   -> frames whose bit count differs from WORD_BITS
//                               raise a one-cycle frame_err pulse and are
//                               discarded.
//                  undefined -> frame_err is tied low; frames of WORD_BITS or
//                               more bits emit their first WORD_BITS bits,
//                               shorter frames are silently dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_deserializer #(
  parameter int WORD_BITS   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 DataBit,
  input  logic                 SPI_clk,
  input  logic                 CS,
  output logic [WORD_BITS-1:0] Data_Out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_st_wait_idle = 2'd0;
  localparam logic [1:0] c_st_idle      = 2'd1;
  localparam logic [1:0] c_st_recv      = 2'd2;

  // Bit counter compare points; the counter stops one past a full word so
  // that "too long" stays distinguishable from "exactly right".
  localparam logic [5:0] c_cnt_word = 6'(WORD_BITS);
  localparam logic [5:0] c_cnt_sat  = 6'(WORD_BITS + 1);

  // Cycles after reset release until the synchronizer outputs reflect the
  // pins rather than their reset value of 1.
  localparam logic [1:0] c_flush_cycles = 2'(SYNC_STAGES);

  // --------------------------------------------------------------------------
  // Synchronizers and edge-detect registers
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   data_edge_q;
  logic                   sclk_edge_q;
  logic                   cs_edge_q;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   sclk_rise;
  logic                   cs_rise;
  logic                   cs_fall;

  // Shift each asynchronous input through its synchronizer chain, then one
  // more register that holds the previous synchronized value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sync_q <= '1;
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      data_edge_q <= 1'b1;
      sclk_edge_q <= 1'b1;
      cs_edge_q   <= 1'b1;
    end else begin
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], DataBit};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   CS};
      data_edge_q <= data_sync_q[SYNC_STAGES-1];
      sclk_edge_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_edge_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_edge_q;
  assign cs_rise   = cs_s & ~cs_edge_q;
  assign cs_fall   = ~cs_s & cs_edge_q;

  // --------------------------------------------------------------------------
  // Post-reset flush counter
  // --------------------------------------------------------------------------
  // The synchronizers come out of reset holding 1, which would look like CS
  // high even when the pin is low mid-frame. Counting SYNC_STAGES cycles
  // before trusting cs_s keeps a frame interrupted by reset from being
  // picked up halfway through.
  logic [1:0] flush_q;
  logic       flush_done;

  assign flush_done = (flush_q == c_flush_cycles);

  // Count up to the synchronizer depth after reset, then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q <= 2'd0;
    end else if (!flush_done) begin
      flush_q <= flush_q + 2'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Receive state machine and datapath
  // --------------------------------------------------------------------------
  logic [1:0]           state_q,  state_d;
  logic [WORD_BITS-1:0] shift_q,  shift_d;
  logic [5:0]           cnt_q,    cnt_d;
  logic [WORD_BITS-1:0] dout_q,   dout_d;
  logic                 valid_q,  valid_d;

  // Values after this cycle's bit (if any) is taken, so that a clock edge and
  // a CS rise seen together still count the final bit before closing.
  logic [WORD_BITS-1:0] shift_nx;
  logic [5:0]           cnt_nx;

`ifdef SPI_DESER_FRAME_CHECK_EN
  logic                 ferr_q, ferr_d;
`endif

  // Next-state, shift register, counter and output-word logic.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    shift_nx = shift_q;
    cnt_nx   = cnt_q;
`ifdef SPI_DESER_FRAME_CHECK_EN
    ferr_d   = 1'b0;
`endif

    case (state_q)
      c_st_wait_idle: begin
        // Only leave once the bus is genuinely deselected.
        if (flush_done && cs_s) begin
          state_d = c_st_idle;
        end
      end

      c_st_idle: begin
        // Clock activity with CS high is ignored here.
        if (cs_fall) begin
          state_d = c_st_recv;
          shift_d = '0;
          cnt_d   = '0;
        end
      end

      c_st_recv: begin
        if (sclk_rise) begin
          // Bits past a full word are counted but not stored, so the word
          // holds the first WORD_BITS bits of an overlong frame.
          if (cnt_q < c_cnt_word) begin
            shift_nx = {shift_q[WORD_BITS-2:0], data_edge_q};
          end
          if (cnt_q != c_cnt_sat) begin
            cnt_nx = cnt_q + 6'd1;
          end
        end
        shift_d = shift_nx;
        cnt_d   = cnt_nx;

        if (cs_rise) begin
          state_d = c_st_idle;
`ifdef SPI_DESER_FRAME_CHECK_EN
          if (cnt_nx == c_cnt_word) begin
            dout_d  = shift_nx;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
`else
          if (cnt_nx >= c_cnt_word) begin
            dout_d  = shift_nx;
            valid_d = 1'b1;
          end
`endif
        end
      end

      default: begin
        state_d = c_st_wait_idle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_st_wait_idle;
      shift_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

`ifdef SPI_DESER_FRAME_CHECK_EN
  // Frame-error strobe register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ferr_q <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
    end
  end

  assign frame_err = ferr_q;
`else
  assign frame_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign Data_Out   = dout_q;
  assign data_valid = valid_q;
  assign busy       = (state_q == c_st_recv);

endmodule

`default_nettype wire

// File: tb/tb_spi_deserializer.sv
// ============================================================================
//  Module      : tb_spi_deserializer
//  Description : Self-checking bench for spi_deserializer. Frames are driven
//                on the SPI pins, a reference model derives the expected
//                outcome from the frame length and content, and a monitor
//                compares every data_valid / frame_err strobe against the
//                expectation queue. Honors SPI_DESER_FRAME_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_deserializer;

  localparam int WORD_BITS   = 32;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  logic                 clk;
  logic                 rst;
  logic                 DataBit;
  logic                 SPI_clk;
  logic                 CS;
  logic [WORD_BITS-1:0] Data_Out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;

  spi_deserializer #(
    .WORD_BITS   (WORD_BITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .DataBit    (DataBit),
    .SPI_clk    (SPI_clk),
    .CS         (CS),
    .Data_Out   (Data_Out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic                 err;
    logic [WORD_BITS-1:0] data;
  } exp_t;

  exp_t                 sb[$];
  int                   total = 0;
  int                   bad   = 0;
  logic [WORD_BITS-1:0] last_data = '0;

  // Monitor: every strobe from the DUT consumes one expectation.
  always @(negedge clk) begin
    if (!rst && (data_valid || frame_err)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: valid=%0b err=%0b data=%h, none expected",
                 data_valid, frame_err, Data_Out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.err) begin
          if (!frame_err || data_valid || Data_Out !== last_data) begin
            bad++;
            $display("FAIL frame_err_strobe: valid=%0b err=%0b data=%h, required err=1 valid=0 data=%h",
                     data_valid, frame_err, Data_Out, last_data);
          end
        end else begin
          if (!data_valid || frame_err || Data_Out !== e.data) begin
            bad++;
            $display("FAIL data_strobe: valid=%0b err=%0b data=%h, required valid=1 err=0 data=%h",
                     data_valid, frame_err, Data_Out, e.data);
          end
          last_data = e.data;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Clock out bits [hi..lo] of w (MSB first), SPI mode 0 style.
  task automatic clock_bits(input logic [63:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      DataBit = w[i];
      cyc(HALF);
      SPI_clk = 1'b1;
      cyc(HALF);
      SPI_clk = 1'b0;
    end
  endtask

  // Reference outcome of a completed frame of n bits, MSB first.
  task automatic model_frame(input logic [63:0] w, input int n);
    exp_t        e;
    logic [63:0] t;
    e.err  = 1'b0;
    e.data = '0;
`ifdef SPI_DESER_FRAME_CHECK_EN
    if (n == WORD_BITS) begin
      e.data = w[WORD_BITS-1:0];
    end else begin
      e.err = 1'b1;
    end
    sb.push_back(e);
`else
    if (n >= WORD_BITS) begin
      t      = w >> (n - WORD_BITS);
      e.data = t[WORD_BITS-1:0];
      sb.push_back(e);
    end
`endif
  endtask

  // Wait (bounded) for all outstanding expectations to be consumed.
  task automatic drain(input string name);
    int budget;
    budget = 60;
    while (sb.size() != 0 && budget > 0) begin
      cyc(1);
      budget--;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: %0d strobes pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic send_frame(input string name, input logic [63:0] w, input int n);
    CS = 1'b0;
    cyc(HALF);
    check({name, "_busy_in"}, {63'd0, busy}, 64'd1);
    if (n > 0) clock_bits(w, n - 1, 0);
    cyc(HALF);
    CS = 1'b1;
    model_frame(w, n);
    drain(name);
    cyc(10);
    check({name, "_busy_out"}, {63'd0, busy}, 64'd0);
    check({name, "_hold"}, {32'd0, Data_Out}, {32'd0, last_data});
  endtask

  initial begin
    logic [63:0] w;
    int          n;

    rst     = 1'b1;
    CS      = 1'b1;
    SPI_clk = 1'b0;
    DataBit = 1'b0;
    cyc(5);
    check("rst_data",  {32'd0, Data_Out}, 64'd0);
    check("rst_valid", {63'd0, data_valid}, 64'd0);
    check("rst_err",   {63'd0, frame_err}, 64'd0);
    check("rst_busy",  {63'd0, busy}, 64'd0);
    rst = 1'b0;
    cyc(10);

    // Directed words, back to back.
    send_frame("word1", 64'h0000_0000_009E_6D55, 32);
    send_frame("word2", 64'h0000_0000_0080_F0FE, 32);

    // Short and long frames.
    w = {$urandom, $urandom};
    send_frame("short20", w, 20);
    w = {$urandom, $urandom};
    send_frame("long33", w, 33);

    // Reset in the middle of a frame, released while CS is still low.
    w = {32'd0, $urandom};
    CS = 1'b0;
    cyc(HALF);
    clock_bits(w, 31, 22);
    rst = 1'b1;
    cyc(3);
    last_data = '0;
    check("midrst_data", {32'd0, Data_Out}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    clock_bits(w, 21, 0);
    cyc(HALF);
    CS = 1'b1;
    cyc(20);
    check("midrst_drop", {32'd0, Data_Out}, 64'd0);
    send_frame("after_rst", 64'h0000_0000_A5A5_A5A5, 32);

    // SPI clock activity while deselected must be ignored.
    for (int i = 0; i < 6; i++) begin
      DataBit = 1'($urandom);
      cyc(HALF);
      SPI_clk = 1'b1;
      cyc(HALF);
      SPI_clk = 1'b0;
    end
    cyc(10);
    check("idle_toggle_quiet", {32'd0, Data_Out}, {32'd0, last_data});
    send_frame("after_idle", {32'd0, $urandom}, 32);

    // Random mix of lengths around the word size.
    for (int k = 0; k < 8; k++) begin
      w = {$urandom, $urandom};
      n = (k % 2 == 0) ? 32 : int'($urandom_range(1, 40));
      send_frame("rand", w, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit as a safety net.
  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
